// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle between an interconnect master port and axi_sram_slave.
interface axi_sram_slave_if #(
   parameter int unsigned ID_W = 8
);
   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [3:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awvalid;
   logic            awready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;
   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [3:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready;
   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output awready, wready, bid, bresp, bvalid,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave serving one transaction at a time from a single-port SRAM.
// Bursts of 32-bit words, every burst type handled as INCR, word address wraps at the SRAM size.
// Optional feature: define AXI_SRAM_RANGE_CHK_EN to reject beats addressed above the SRAM
// (no access, SLVERR response); without it upper address bits alias and responses are OKAY.
module axi_sram_slave #(
   parameter int unsigned ID_W    = 8,
   parameter int unsigned SRAM_AW = 14
) (
   input  logic               clk,
   input  logic               rst,
   axi_sram_slave_if.slave    io_axi,
   output logic               o_sram_cs,
   output logic [3:0]         o_sram_we,
   output logic [SRAM_AW-1:0] o_sram_addr,
   output logic [31:0]        o_sram_di,
   input  logic [31:0]        i_sram_do
);
   typedef enum logic [2:0] {StIdle, StRFetch, StRData, StWData, StWResp} state_e;

   state_e             r_state, w_state_nx;
   logic [ID_W-1:0]    r_id, w_id_nx;
   logic [SRAM_AW-1:0] r_addr, w_addr_nx;
   logic [3:0]         r_len, w_len_nx;
   logic [3:0]         r_beat, w_beat_nx;
   logic               r_oor, w_oor_nx;
   logic               r_wr_err, w_wr_err_nx;
   logic               r_last_wr, w_last_wr_nx;

   logic               w_both, w_aw_gnt, w_ar_gnt;
   logic [31:0]        w_grant_addr;
   logic [SRAM_AW-1:0] w_addr_inc;
   logic               w_carry, w_grant_oor, w_inc_oor, w_last_beat, w_wr_acc;
   logic               w_unused;

   // Arbitration: with both requests pending, grant alternates based on the last served type.
   assign w_both          = io_axi.awvalid & io_axi.arvalid;
   assign io_axi.awready  = (r_state == StIdle) & ~(w_both & r_last_wr);
   assign io_axi.arready  = (r_state == StIdle) & ~(w_both & ~r_last_wr);
   assign w_aw_gnt        = io_axi.awvalid & io_axi.awready;
   assign w_ar_gnt        = io_axi.arvalid & io_axi.arready;
   assign w_grant_addr    = w_aw_gnt ? io_axi.awaddr : io_axi.araddr;
   assign {w_carry, w_addr_inc} = {1'b0, r_addr} + (SRAM_AW+1)'(1);
   assign w_last_beat     = (r_beat == r_len);
   assign w_wr_acc        = (|io_axi.wstrb) & ~r_oor;

`ifdef AXI_SRAM_RANGE_CHK_EN
   // Out of range is sticky: once the burst leaves the SRAM it never comes back.
   assign w_grant_oor = |w_grant_addr[31:SRAM_AW+2];
   assign w_inc_oor   = r_oor | w_carry;
`else
   assign w_grant_oor = 1'b0;
   assign w_inc_oor   = 1'b0;
`endif

   // Size is assumed to be one word and burst type is not decoded.
   assign w_unused = ^{io_axi.awsize, io_axi.arsize, io_axi.awburst, io_axi.arburst,
                       w_grant_addr[1:0], w_grant_addr[31:SRAM_AW+2], w_carry};

   // Next-state, channel outputs and SRAM strobes.
   always_comb begin
      w_state_nx   = r_state;
      w_id_nx      = r_id;
      w_addr_nx    = r_addr;
      w_len_nx     = r_len;
      w_beat_nx    = r_beat;
      w_oor_nx     = r_oor;
      w_wr_err_nx  = r_wr_err;
      w_last_wr_nx = r_last_wr;
      io_axi.wready = 1'b0;
      io_axi.bvalid = 1'b0;
      io_axi.bid    = '0;
      io_axi.bresp  = 2'b00;
      io_axi.rvalid = 1'b0;
      io_axi.rid    = '0;
      io_axi.rdata  = '0;
      io_axi.rresp  = 2'b00;
      io_axi.rlast  = 1'b0;
      o_sram_cs     = 1'b0;
      o_sram_we     = 4'b0000;
      o_sram_addr   = r_addr;
      o_sram_di     = '0;
      unique case (r_state)
         StIdle: begin
            if (w_aw_gnt || w_ar_gnt) begin
               w_id_nx     = w_aw_gnt ? io_axi.awid : io_axi.arid;
               w_addr_nx   = w_grant_addr[SRAM_AW+1:2];
               w_len_nx    = w_aw_gnt ? io_axi.awlen : io_axi.arlen;
               w_beat_nx   = '0;
               w_oor_nx    = w_grant_oor;
               w_wr_err_nx = 1'b0;
               w_state_nx  = w_aw_gnt ? StWData : StRFetch;
            end
         end
         StRFetch: begin
            o_sram_cs  = ~r_oor;
            w_state_nx = StRData;
         end
         StRData: begin
            // SRAM output is held until the next access, so RDATA stays stable while stalled.
            io_axi.rvalid = 1'b1;
            io_axi.rid    = r_id;
            io_axi.rdata  = r_oor ? 32'h0 : i_sram_do;
            io_axi.rresp  = r_oor ? 2'b10 : 2'b00;
            io_axi.rlast  = w_last_beat;
            if (io_axi.rready) begin
               if (w_last_beat) begin
                  w_last_wr_nx = 1'b0;
                  w_state_nx   = StIdle;
               end else begin
                  w_addr_nx  = w_addr_inc;
                  w_beat_nx  = r_beat + 4'd1;
                  w_oor_nx   = w_inc_oor;
                  w_state_nx = StRFetch;
               end
            end
         end
         StWData: begin
            io_axi.wready = 1'b1;
            if (io_axi.wvalid) begin
               o_sram_cs   = w_wr_acc;
               o_sram_we   = w_wr_acc ? io_axi.wstrb : 4'b0000;
               o_sram_di   = io_axi.wdata;
               w_wr_err_nx = r_wr_err | r_oor;
               w_addr_nx   = w_addr_inc;
               w_beat_nx   = r_beat + 4'd1;
               w_oor_nx    = w_inc_oor;
               if (io_axi.wlast) begin
                  w_state_nx = StWResp;
               end
            end
         end
         StWResp: begin
            io_axi.bvalid = 1'b1;
            io_axi.bid    = r_id;
            io_axi.bresp  = r_wr_err ? 2'b10 : 2'b00;
            if (io_axi.bready) begin
               w_last_wr_nx = 1'b1;
               w_state_nx   = StIdle;
            end
         end
         default: w_state_nx = StIdle;
      endcase
   end

   // State and transaction context registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_id      <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_oor     <= 1'b0;
         r_wr_err  <= 1'b0;
         r_last_wr <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_id      <= w_id_nx;
         r_addr    <= w_addr_nx;
         r_len     <= w_len_nx;
         r_beat    <= w_beat_nx;
         r_oor     <= w_oor_nx;
         r_wr_err  <= w_wr_err_nx;
         r_last_wr <= w_last_wr_nx;
      end
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: table of directed transactions plus hand-written
// sequences for arbitration, read back-pressure and reset in the middle of a write burst.
module tb_axi_sram_slave;
   localparam int unsigned ID_W    = 8;
   localparam int unsigned SRAM_AW = 14;
   localparam int unsigned Depth   = 1 << SRAM_AW;
   localparam int          NumVec  = 9;
`ifdef AXI_SRAM_RANGE_CHK_EN
   localparam bit RChk = 1'b1;
`else
   localparam bit RChk = 1'b0;
`endif

   typedef struct packed {
      logic            wr;
      logic [7:0]      id;
      logic [31:0]     addr;
      logic [3:0]      len;
      logic [3:0][31:0] data;
      logic [3:0][3:0]  strb;
      logic [3:0][31:0] exp;
      logic [3:0][1:0]  resp;
      logic [3:0]       noacc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_sram_slave_if #(.ID_W(ID_W)) axi ();
   logic               sram_cs;
   logic [3:0]         sram_we;
   logic [SRAM_AW-1:0] sram_addr;
   logic [31:0]        sram_di;
   logic [31:0]        sram_do;

   axi_sram_slave #(.ID_W(ID_W), .SRAM_AW(SRAM_AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .io_axi     (axi),
      .o_sram_cs  (sram_cs),
      .o_sram_we  (sram_we),
      .o_sram_addr(sram_addr),
      .o_sram_di  (sram_di),
      .i_sram_do  (sram_do)
   );

   // SRAM model with a back-door preload port and an access counter.
   logic [31:0]        mem [Depth];
   int unsigned        acc_cnt = 0;
   logic               pl_we = 1'b0;
   logic [SRAM_AW-1:0] pl_addr = '0;
   logic [31:0]        pl_data = '0;
   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end else if (sram_cs) begin
         acc_cnt <= acc_cnt + 1;
         if (sram_we == 4'b0000) begin
            sram_do <= mem[sram_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
            end
         end
      end
   end

   int n_checks = 0;
   int n_err    = 0;
   vec_t vecs [NumVec];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [SRAM_AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_awready"}, 32'(axi.awready), 32'h1);
      chk({tag, "_arready"}, 32'(axi.arready), 32'h1);
      chk({tag, "_wready"},  32'(axi.wready),  32'h0);
      chk({tag, "_bvalid"},  32'(axi.bvalid),  32'h0);
      chk({tag, "_rvalid"},  32'(axi.rvalid),  32'h0);
      chk({tag, "_rlast"},   32'(axi.rlast),   32'h0);
      chk({tag, "_rdata"},   axi.rdata,        32'h0);
      chk({tag, "_ids"},     32'({axi.bid, axi.rid}), 32'h0);
      chk({tag, "_resps"},   32'({axi.bresp, axi.rresp}), 32'h0);
      chk({tag, "_sram_cs"}, 32'(sram_cs),     32'h0);
      chk({tag, "_sram_we"}, 32'(sram_we),     32'h0);
   endtask

   task automatic aw_hs();
      int n = 0;
      axi.awvalid = 1'b1;
      #1;
      while (!axi.awready && n < 20) begin @(negedge clk); #1; n++; end
      chk("aw_ready", 32'(axi.awready), 32'h1);
      @(negedge clk);
      axi.awvalid = 1'b0;
   endtask

   task automatic ar_hs();
      int n = 0;
      axi.arvalid = 1'b1;
      #1;
      while (!axi.arready && n < 20) begin @(negedge clk); #1; n++; end
      chk("ar_ready", 32'(axi.arready), 32'h1);
      @(negedge clk);
      axi.arvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                         input logic exp_cs, input logic [SRAM_AW-1:0] exp_addr);
      int n = 0;
      axi.wdata = d; axi.wstrb = s; axi.wlast = last; axi.wvalid = 1'b1;
      #1;
      while (!axi.wready && n < 20) begin @(negedge clk); #1; n++; end
      chk("w_ready", 32'(axi.wready), 32'h1);
      chk("w_sram_cs", 32'(sram_cs), 32'(exp_cs));
      chk("w_sram_we", 32'(sram_we), exp_cs ? 32'(s) : 32'h0);
      if (exp_cs) chk("w_sram_addr", 32'(sram_addr), 32'(exp_addr));
      @(negedge clk);
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
   endtask

   task automatic b_phase(input logic [7:0] exp_id, input logic [1:0] exp_resp);
      int n = 0;
      #1;
      while (!axi.bvalid && n < 20) begin @(negedge clk); #1; n++; end
      chk("b_valid", 32'(axi.bvalid), 32'h1);
      chk("b_id", 32'(axi.bid), 32'(exp_id));
      chk("b_resp", 32'(axi.bresp), 32'(exp_resp));
      axi.bready = 1'b1;
      @(negedge clk);
      axi.bready = 1'b0;
      #1;
      chk("b_done", 32'(axi.bvalid), 32'h0);
   endtask

   // Entered on the falling edge right after the previous handshake.
   task automatic r_beat(input logic [31:0] exp_d, input logic [7:0] exp_id, input logic exp_last,
                         input logic [1:0] exp_resp, input int stall);
      int n = 0;
      int unsigned acc0;
      axi.rready = 1'b0;
      do begin @(negedge clk); #1; n++; end while (!axi.rvalid && n < 20);
      chk("r_latency", 32'(n), 32'd1);
      chk("r_data", axi.rdata, exp_d);
      chk("r_id", 32'(axi.rid), 32'(exp_id));
      chk("r_last", 32'(axi.rlast), 32'(exp_last));
      chk("r_resp", 32'(axi.rresp), 32'(exp_resp));
      acc0 = acc_cnt;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         chk("stall_rvalid", 32'(axi.rvalid), 32'h1);
         chk("stall_rdata", axi.rdata, exp_d);
         chk("stall_rid_rlast", 32'({axi.rid, axi.rlast}), 32'({exp_id, exp_last}));
         chk("stall_sram_acc", acc_cnt, acc0);
      end
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      if (v.wr) begin
         axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len;
         axi.awsize = 3'b010; axi.awburst = 2'b01;
         aw_hs();
         for (int b = 0; b <= int'(v.len); b++) begin
            w_beat(v.data[b], v.strb[b], b == int'(v.len), (|v.strb[b]) & ~v.noacc[b],
                   SRAM_AW'((v.addr >> 2) + 32'(b)));
         end
         b_phase(v.id, v.resp[0]);
      end else begin
         axi.arid = v.id; axi.araddr = v.addr; axi.arlen = v.len;
         axi.arsize = 3'b010; axi.arburst = 2'b01;
         ar_hs();
         for (int b = 0; b <= int'(v.len); b++) begin
            r_beat(v.exp[b], v.id, b == int'(v.len), v.resp[b], 0);
         end
      end
   endtask

   function automatic vec_t mkv(input logic wr, input logic [7:0] id, input logic [31:0] addr,
                                input logic [3:0] len, input logic [127:0] d,
                                input logic [15:0] s, input logic [127:0] e,
                                input logic [7:0] r, input logic [3:0] na);
      vec_t v;
      v.wr = wr; v.id = id; v.addr = addr; v.len = len;
      v.data = d; v.strb = s; v.exp = e; v.resp = r; v.noacc = na;
      return v;
   endfunction

   initial begin
      vecs[0] = mkv(1'b0, 8'h12, 32'h14, 4'd0, '0, '0, {96'h0, 32'hDEADBEEF}, 8'h00, 4'h0);
      vecs[1] = mkv(1'b1, 8'h34, 32'h100, 4'd3,
                    {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304},
                    {4'b1000, 4'b0000, 4'b0011, 4'b1111}, '0, 8'h00, 4'h0);
      vecs[2] = mkv(1'b0, 8'h56, 32'h100, 4'd3, '0, '0,
                    {32'h0DD3D3D3, 32'hC2C2C2C2, 32'hB1B10708, 32'h01020304}, 8'h00, 4'h0);
      vecs[3] = mkv(1'b1, 8'h07, 32'h200, 4'd1, {64'h0, 32'h12345678, 32'hCAFEF00D},
                    16'h00FF, '0, 8'h00, 4'h0);
      vecs[4] = mkv(1'b0, 8'h08, 32'h200, 4'd1, '0, '0, {64'h0, 32'h12345678, 32'hCAFEF00D},
                    8'h00, 4'h0);
      vecs[5] = mkv(1'b0, 8'h5A, 32'h0001_0014, 4'd0, '0, '0,
                    {96'h0, RChk ? 32'h0 : 32'hDEADBEEF}, RChk ? 8'h02 : 8'h00, 4'h0);
      vecs[6] = mkv(1'b1, 8'h66, 32'h0001_0300, 4'd0, {96'h0, 32'h55AA55AA}, 16'h000F, '0,
                    RChk ? 8'h02 : 8'h00, RChk ? 4'h1 : 4'h0);
      vecs[7] = mkv(1'b0, 8'h77, 32'h300, 4'd0, '0, '0,
                    {96'h0, RChk ? 32'h0BADF00D : 32'h55AA55AA}, 8'h00, 4'h0);
      vecs[8] = mkv(1'b0, 8'h99, 32'hFFFC, 4'd1, '0, '0,
                    {64'h0, RChk ? 32'h0 : 32'h0F0F0F0F, 32'h600DCAFE},
                    RChk ? 8'h08 : 8'h00, 4'h0);

      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'b010; axi.awburst = 2'b01;
      axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'b010;
      axi.arburst = 2'b01; axi.arvalid = 1'b0; axi.rready = 1'b0;

      #2 rst = 1'b0;
      preload(14'd5, 32'hDEADBEEF);
      preload(14'd64, 32'hA0A0A0A0);
      preload(14'd65, 32'hB1B1B1B1);
      preload(14'd66, 32'hC2C2C2C2);
      preload(14'd67, 32'hD3D3D3D3);
      preload(14'd192, 32'h0BADF00D);
      preload(14'd16383, 32'h600DCAFE);
      preload(14'd0, 32'h0F0F0F0F);
      preload(14'd320, 32'hAAAA0000);
      preload(14'd321, 32'h9999AAAA);
      #1 chk_idle("in_reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1 chk_idle("after_reset");

      // Both address channels valid out of reset: write first, then read, then write again.
      @(negedge clk);
      axi.awid = 8'h21; axi.awaddr = 32'h400; axi.awlen = 4'd0; axi.awvalid = 1'b1;
      axi.arid = 8'h22; axi.araddr = 32'h400; axi.arlen = 4'd0; axi.arvalid = 1'b1;
      #1;
      chk("arb1_awready", 32'(axi.awready), 32'h1);
      chk("arb1_arready", 32'(axi.arready), 32'h0);
      aw_hs();
      #1 chk("arb1_ar_held", 32'(axi.arready), 32'h0);
      w_beat(32'h77777777, 4'hF, 1'b1, 1'b1, 14'd256);
      b_phase(8'h21, 2'b00);
      axi.awid = 8'h23; axi.awvalid = 1'b1;
      #1;
      chk("arb2_awready", 32'(axi.awready), 32'h0);
      chk("arb2_arready", 32'(axi.arready), 32'h1);
      ar_hs();
      r_beat(32'h77777777, 8'h22, 1'b1, 2'b00, 0);
      aw_hs();
      w_beat(32'h88888888, 4'hF, 1'b1, 1'b1, 14'd256);
      b_phase(8'h23, 2'b00);

      for (int i = 0; i < NumVec; i++) run_vec(vecs[i]);

      // Back-pressure on the second beat of a 4-beat read.
      begin
         int unsigned acc_start;
         acc_start = acc_cnt;
         axi.arid = 8'h3C; axi.araddr = 32'h100; axi.arlen = 4'd3;
         ar_hs();
         r_beat(32'h01020304, 8'h3C, 1'b0, 2'b00, 0);
         r_beat(32'hB1B10708, 8'h3C, 1'b0, 2'b00, 5);
         r_beat(32'hC2C2C2C2, 8'h3C, 1'b0, 2'b00, 0);
         r_beat(32'h0DD3D3D3, 8'h3C, 1'b1, 2'b00, 0);
         chk("stall_total_acc", acc_cnt - acc_start, 32'd4);
      end

      // Reset while the second write beat is being offered.
      axi.awid = 8'h44; axi.awaddr = 32'h500; axi.awlen = 4'd3;
      aw_hs();
      w_beat(32'h11112222, 4'hF, 1'b0, 1'b1, 14'd320);
      axi.wdata = 32'hDEADDEAD; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      rst = 1'b0;
      #1 chk_idle("mid_burst_rst");
      @(negedge clk);
      axi.wvalid = 1'b0;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("post_rst_no_bvalid", 32'(axi.bvalid), 32'h0);
      end
      @(negedge clk);
      axi.arid = 8'h45; axi.araddr = 32'h500; axi.arlen = 4'd1;
      ar_hs();
      r_beat(32'h11112222, 8'h45, 1'b0, 2'b00, 0);
      r_beat(32'h9999AAAA, 8'h45, 1'b1, 2'b00, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
